uc_hazard_hold: RTL

//  Decode-stage hazard unit. Tracks the destination registers (busC) of

---
 rtl/uc_hazard_hold.sv | 90 +++++++++
 1 files changed

// File: rtl/uc_hazard_hold.sv
// Decode-stage hazard unit: RAW detection against in-flight destinations, memory-wait freeze, saturating stall counter.
// Optional macro FORWARDING_EN: WB-slot matches are bypassed (FWD_A/FWD_B) instead of stalled.
module uc_hazard_hold #(
  parameter int         DEPTH    = 3,
  parameter logic [5:0] NULL_REG = 6'd0,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID_in,
  input  logic [5:0]       busA_in,
  input  logic [5:0]       busB_in,
  input  logic [5:0]       busC_in,
  input  logic             MEM_BUSY,
  input  logic             CNT_CLR,
  output logic             HOLD,
  output logic             FREEZE,
  output logic [CNT_W-1:0] HOLD_CNT,
  output logic             FWD_A,
  output logic             FWD_B
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0][5:0] dst_q, dst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0]      match_a, match_b, chk_mask;
  logic                  raw, issue;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = vld_q[i] && (busA_in != NULL_REG) && (busA_in == dst_q[i]);
      match_b[i] = vld_q[i] && (busB_in != NULL_REG) && (busB_in == dst_q[i]);
    end
  end

`ifdef FORWARDING_EN
  // WB slot is bypassed, but only when no younger slot holds a newer value.
  assign chk_mask = {1'b0, {(DEPTH-1){1'b1}}};
  assign FWD_A    = VALID_in && match_a[DEPTH-1] && !(|match_a[DEPTH-2:0]);
  assign FWD_B    = VALID_in && match_b[DEPTH-1] && !(|match_b[DEPTH-2:0]);
`else
  assign chk_mask = '1;
  assign FWD_A    = 1'b0;
  assign FWD_B    = 1'b0;
`endif

  assign raw      = VALID_in && (|((match_a | match_b) & chk_mask));
  assign FREEZE   = MEM_BUSY;
  assign HOLD     = raw | FREEZE;
  assign issue    = VALID_in && !HOLD;
  assign HOLD_CNT = cnt_q;

  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    if (!FREEZE) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        dst_d[i] = dst_q[i-1];
      end
      // A held or invalid uinst becomes a bubble in EX.
      vld_d[0] = issue && (busC_in != NULL_REG);
      dst_d[0] = issue ? busC_in : NULL_REG;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (HOLD && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      dst_q <= {DEPTH{NULL_REG}};
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
